// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: data width, operation encoding, FSM states.
package mdu_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // funct3 encoding of the RV32M operations
  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op_is_rem(input mdu_op_e op);
    return op inside {MDU_REM, MDU_REMU};
  endfunction

  function automatic logic op1_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic op2_signed(input mdu_op_e op);
    return op inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Unsigned radix-2 restoring divider: WIDTH iterations, the first one folded into the load cycle
// so that done pulses WIDTH cycles after start.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] dvsr_q;
  logic [WIDTH-1:0] rem_in;
  logic [WIDTH-1:0] quo_in;
  logic [WIDTH-1:0] dvsr_in;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  // One restoring step; the borrow bit of the trial subtraction is the inverted quotient bit
  always_comb begin
    rem_in  = start ? '0 : remainder;
    quo_in  = start ? dividend : quotient;
    dvsr_in = start ? divisor : dvsr_q;
    trial   = {rem_in, quo_in[WIDTH-1]};
    diff    = trial - {1'b0, dvsr_in};
    rem_nx  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx  = {quo_in[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvsr_q    <= '0;
      quotient  <= '0;
      remainder <= '0;
      cnt_q     <= '0;
      active_q  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end else if (start) begin
        remainder <= rem_nx;
        quotient  <= quo_nx;
        dvsr_q    <= divisor;
        cnt_q     <= CNT_W'(WIDTH - 1);
        active_q  <= 1'b1;
      end else if (active_q) begin
        remainder <= rem_nx;
        quotient  <= quo_nx;
        cnt_q     <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          active_q <= 1'b0;
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32M multiply/divide unit with IDLE/CALC/DONE control and sign fix-up around unsigned datapaths.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier instead of shift-add.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  mdu_op_e          mdu_op_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned PROD_W = 2 * WIDTH;
  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  mdu_state_e       state_q, state_d;
  mdu_op_e          op_q, op_d;
  logic [WIDTH-1:0] mag1_q, mag1_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic [WIDTH-1:0] result_d;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;

  // Operand decode at acceptance: magnitudes plus the sign flags needed for fix-up
  logic             in_neg1, in_neg2, in_div0, in_ovf;
  logic [WIDTH-1:0] in_mag1, in_mag2, special_res;

  assign in_neg1 = op1_signed(mdu_op_i) & operand1_i[WIDTH-1];
  assign in_neg2 = op2_signed(mdu_op_i) & operand2_i[WIDTH-1];
  assign in_mag1 = in_neg1 ? (~operand1_i + WIDTH'(1)) : operand1_i;
  assign in_mag2 = in_neg2 ? (~operand2_i + WIDTH'(1)) : operand2_i;
  assign in_div0 = op_is_div(mdu_op_i) && (operand2_i == '0);
  assign in_ovf  = op_is_div(mdu_op_i) && op1_signed(mdu_op_i) &&
                   (operand1_i == MOST_NEG) && (operand2_i == '1);
  assign special_res = op_is_rem(mdu_op_i) ? (in_div0 ? operand1_i : '0)
                                           : (in_div0 ? '1 : MOST_NEG);

  logic [PROD_W-1:0] mul_prod;
  logic [PROD_W-1:0] mul_fixed;
  logic [WIDTH-1:0]  mul_res;
  logic              mul_last;

`ifdef MDU_FAST_MUL_EN
  logic [WIDTH-1:0] mag2_q, mag2_d;

  assign mul_prod = PROD_W'(mag1_q) * PROD_W'(mag2_q);
  assign mul_last = 1'b1;
`else
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]    mul_sum;

  // Shift-add: upper half accumulates the multiplicand, lower half shifts the multiplier out
  assign mul_sum  = {1'b0, prod_q[PROD_W-1:WIDTH]} + (prod_q[0] ? {1'b0, mag1_q} : '0);
  assign mul_prod = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_last = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  assign mul_fixed = neg_a_q ? -mul_prod : mul_prod;
  assign mul_res   = (op_q == MDU_MUL) ? mul_fixed[WIDTH-1:0] : mul_fixed[PROD_W-1:WIDTH];

  logic [WIDTH-1:0] div_res;
  assign div_res = op_is_rem(op_q) ? (neg_b_q ? -div_rem : div_rem)
                                   : (neg_a_q ? -div_quo : div_quo);

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .dividend  (in_mag1),
    .divisor   (in_mag2),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    mag1_d    = mag1_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    result_d  = result_o;
    div_start = 1'b0;
`ifdef MDU_FAST_MUL_EN
    mag2_d    = mag2_q;
`else
    prod_d    = prod_q;
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          op_d    = mdu_op_i;
          mag1_d  = in_mag1;
          neg_a_d = in_neg1 ^ in_neg2;
          neg_b_d = in_neg1;
`ifdef MDU_FAST_MUL_EN
          mag2_d  = in_mag2;
`else
          prod_d  = {WIDTH'(0), in_mag2};
          cnt_d   = '0;
`endif
          if (in_div0 || in_ovf) begin
            state_d  = ST_DONE;
            result_d = special_res;
          end else begin
            state_d   = ST_CALC;
            div_start = op_is_div(mdu_op_i);
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (op_is_div(op_q)) begin
          if (div_done) begin
            state_d  = ST_DONE;
            result_d = div_res;
          end
        end else begin
`ifndef MDU_FAST_MUL_EN
          prod_d = mul_prod;
          cnt_d  = cnt_q + CNT_W'(1);
`endif
          if (mul_last) begin
            state_d  = ST_DONE;
            result_d = mul_res;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MDU_MUL;
      mag1_q   <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
`ifdef MDU_FAST_MUL_EN
      mag2_q   <= '0;
`else
      prod_q   <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mag1_q   <= mag1_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      busy_o   <= (state_d != ST_IDLE);
      valid_o  <= (state_d == ST_DONE);
      result_o <= result_d;
`ifdef MDU_FAST_MUL_EN
      mag2_q   <= mag2_d;
`else
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter WIDTH, default DATA_WIDTH (from defines), meaning operand/result width in bits; even, >= 8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request; sampled on a rising edge only while in IDLE.
REQ-005 SHALL have port mdu_op_i  input  mdu_op_e  operation select, sampled with start_i.
REQ-006 SHALL have port operand1_i  input  WIDTH  rs1 value / dividend, sampled with start_i.
REQ-007 SHALL have port operand2_i  input  WIDTH  rs2 value / divisor, sampled with start_i.
REQ-008 SHALL have port flush_i  input  1  aborts any in-flight operation.
REQ-009 SHALL have port busy_o  output  1  high in CALC and DONE.
REQ-010 SHALL have port valid_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result_o  output  WIDTH  result; held stable from valid_o until the next accepted start.

Function
REQ-012 SHALL implement MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU with RV32M semantics generalised to WIDTH.
REQ-013 SHALL use FSM IDLE -> CALC -> DONE -> IDLE; IDLE -> DONE directly for special cases; DONE lasts exactly one cycle.
REQ-014 SHALL latch op and operands on the accepting edge; input changes after acceptance SHALL have no effect.
REQ-015 SHALL assert valid_o only in DONE; start_i outside IDLE SHALL be ignored, not queued.
REQ-016 SHALL divide iteratively, radix-2 restoring, on magnitudes with sign fix-up: WIDTH cycles in CALC; valid_o WIDTH+1 cycles after the accepting edge.
REQ-017 SHALL multiply with a 2*WIDTH-bit product; low half for MUL, high half for MULH*, with signed/unsigned per operand as RV32M.
REQ-018 SHALL, for division by zero, skip CALC (valid_o 1 cycle after accept); quotient all ones, remainder = operand1.
REQ-019 SHALL, for signed overflow (most-negative / -1), skip CALC; quotient = most-negative, remainder = 0.
REQ-020 SHALL give signed remainder the sign of the dividend, with truncation toward zero.
REQ-021 SHALL, on flush_i, enter IDLE on the next edge; it SHALL not pulse valid_o and SHALL leave result_o unchanged.
REQ-022 SHALL give flush_i priority over start_i on the same edge (start not accepted).
REQ-023 SHALL accept a start in IDLE on the edge immediately after DONE (back-to-back throughput).

Reset
REQ-024 SHALL, on rst high, asynchronously force state IDLE, busy_o=0, valid_o=0, result_o=0, and all internal counters/accumulators to 0.
REQ-025 SHALL discard an in-flight operation when rst is asserted mid-operation; no valid_o after release.

Configuration
REQ-026 SHALL use macro MDU_FAST_MUL_EN: when defined, multiplies use a single-cycle combinational product with one CALC cycle, giving valid_o 2 cycles after accept.
REQ-027 SHALL, when MDU_FAST_MUL_EN is undefined, compute multiplies by iterative shift-add: WIDTH CALC cycles, giving valid_o WIDTH+1 cycles after accept; results are identical either way.

Structure
REQ-028 SHALL place typedef enum mdu_op_e (3 bits, funct3 encoding MUL=0 ... REMU=7) in the defines package.
REQ-029 SHALL place the iterative divider in sub-module mdu_divider (start/done handshake, WIDTH parameter); FSM, sign handling and multiplier stay in mdu.

Verification
REQ-030 SHALL cover MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB; valid_o at +33 cycles (+2 with MDU_FAST_MUL_EN).
REQ-031 SHALL cover MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE, and MULH on the same operands -> 0x00000000.
REQ-032 SHALL cover DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA, and REM on the same operands -> 0xFFFFFFFE; valid_o at +33 cycles.
REQ-033 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF, REMU 5 / 0 -> 5, and DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 (REM -> 0); each with valid_o at +1 cycle.
REQ-034 SHALL cover flush_i at CALC cycle 10 -> no valid_o, busy_o low next cycle, result_o unchanged, and the next DIVU 100 / 7 -> 14.
REQ-035 SHALL cover rst pulse mid-CALC -> all outputs 0 immediately, no valid_o after release; plus start_i held during busy -> exactly one valid_o.
